// File: rtl/direction_input_ctrl.sv
// direction_input_ctrl: debounces four direction buttons and queues legal turns, applying one per snake tick
module direction_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1064700,
  parameter int QUEUE_DEPTH = 2,
  parameter logic [3:0] INIT_DIR = 4'b1000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic [3:0] i_Buttons,
  input  logic i_SnakeClk,
  output logic [3:0] o_Direction,
  output logic o_Turn,
  output logic o_Dropped,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_QueueCount
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QUEUE_DEPTH - 1);
  logic [3:0] btn_s1, btn_s2, deb, deb_q, rise, opp, last_dir;
  logic [DW-1:0] cnt [4];
  logic [2:0] snk;
  logic [3:0] mem [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic press, tick, pop, push;
  always_comb begin
    rise = deb & ~deb_q;
    press = $onehot(rise) && deb == rise;
    opp = {last_dir[2], last_dir[3], last_dir[0], last_dir[1]};
    tick = snk[1] & ~snk[2];
    pop = tick && o_QueueCount != '0;
    push = press && rise != last_dir && rise != opp && (o_QueueCount != FULL || pop);
  end
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      snk <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_dir <= INIT_DIR;
      o_Direction <= INIT_DIR;
      o_Turn <= 1'b0;
      o_Dropped <= 1'b0;
      o_QueueCount <= '0;
    end else begin
      btn_s1 <= i_Buttons;
      btn_s2 <= btn_s1;
      deb_q <= deb;
      snk <= {snk[1:0], i_SnakeClk};
      for (int i = 0; i < 4; i++)
        if (btn_s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == DMAX) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr == PLAST ? '0 : wr_ptr + 1'b1;
        last_dir <= rise;
      end
      if (pop) begin
        o_Direction <= mem[rd_ptr];
        rd_ptr <= rd_ptr == PLAST ? '0 : rd_ptr + 1'b1;
      end
      o_QueueCount <= o_QueueCount + CW'(push) - CW'(pop);
      o_Turn <= pop;
      o_Dropped <= press && !push;
    end
  always_ff @(posedge i_Clk)
    if (push) mem[wr_ptr] <= rise;
endmodule

// File: tb/tb_direction_input_ctrl.sv
// tb_direction_input_ctrl: directed stimulus with a queued expected-event scoreboard
module tb_direction_input_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] buttons = 4'b0;
  logic snake_clk = 1'b0;
  logic [3:0] dir;
  logic turn, dropped;
  logic [1:0] qcount;
  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  direction_input_ctrl #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .INIT_DIR(4'b1000)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Buttons(buttons), .i_SnakeClk(snake_clk),
    .o_Direction(dir), .o_Turn(turn), .o_Dropped(dropped), .o_QueueCount(qcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event; 6'h20 means nothing was expected
  always @(negedge clk) begin
    logic [5:0] e;
    if (dropped) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 6'h20;
      checks++;
      if (e != 6'h00) begin
        failures++;
        $display("FAIL drop_event: got dropped pulse expected event %0h", e);
      end
    end
    if (turn) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 6'h20;
      checks++;
      if (e != {2'b01, dir}) begin
        failures++;
        $display("FAIL turn_event: got turn to %b expected event %0h", dir, e);
      end
    end
  end

  task automatic press(input logic [3:0] b, input logic drop);
    if (drop) exp_q.push_back(6'h00);
    @(posedge clk) #1 buttons = b;
    repeat (10) @(posedge clk);
    #1 buttons = 4'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic tick(input logic [3:0] exp_dir);
    if (exp_dir != 4'b0) exp_q.push_back({2'b01, exp_dir});
    @(posedge clk) #1 snake_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 snake_clk = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    repeat (8) begin
      @(posedge clk) #1 buttons = 4'($urandom);
    end
    @(negedge clk);
    check("rst_dir", {4'b0, dir}, 8'h08);
    check("rst_count", {6'b0, qcount}, 8'h00);
    check("rst_turn", {7'b0, turn}, 8'h00);
    check("rst_dropped", {7'b0, dropped}, 8'h00);
    buttons = 4'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_dir", {4'b0, dir}, 8'h08);
    check("idle_count", {6'b0, qcount}, 8'h00);

    @(posedge clk) #1 buttons = 4'b0001;
    repeat (3) @(posedge clk);
    #1 buttons = 4'b0;
    repeat (8) @(posedge clk);
    check("glitch_count", {6'b0, qcount}, 8'h00);
    press(4'b0001, 1'b0);
    check("debounce_count", {6'b0, qcount}, 8'h01);
    check("debounce_dir_held", {4'b0, dir}, 8'h08);
    tick(4'b0001);
    check("tick_dir_up", {4'b0, dir}, 8'h01);
    check("tick_count", {6'b0, qcount}, 8'h00);

    press(4'b0100, 1'b0);
    press(4'b1000, 1'b1);
    tick(4'b0100);
    press(4'b1000, 1'b1);
    check("reversal_count", {6'b0, qcount}, 8'h00);
    press(4'b0100, 1'b1);
    press(4'b0010, 1'b0);
    press(4'b0001, 1'b1);
    tick(4'b0010);
    press(4'b0101, 1'b0);
    check("multi_count", {6'b0, qcount}, 8'h00);
    check("multi_dir", {4'b0, dir}, 8'h02);

    press(4'b0100, 1'b0);
    press(4'b0001, 1'b0);
    press(4'b1000, 1'b1);
    check("full_count", {6'b0, qcount}, 8'h02);
    tick(4'b0100);
    tick(4'b0001);
    check("drain_dir", {4'b0, dir}, 8'h01);
    check("drain_count", {6'b0, qcount}, 8'h00);

    press(4'b0100, 1'b0);
    press(4'b0010, 1'b0);
    check("refill_count", {6'b0, qcount}, 8'h02);
    // Button and snake edge aligned so push and pop land on the same clock edge
    exp_q.push_back({2'b01, 4'b0100});
    @(posedge clk) #1 buttons = 4'b1000;
    repeat (4) @(posedge clk);
    #1 snake_clk = 1'b1;
    repeat (6) @(posedge clk);
    #1 buttons = 4'b0;
    snake_clk = 1'b0;
    repeat (10) @(posedge clk);
    check("simul_count", {6'b0, qcount}, 8'h02);
    check("simul_dir", {4'b0, dir}, 8'h04);

    @(negedge clk) #2 rst_n = 1'b0;
    #1;
    check("midrst_dir", {4'b0, dir}, 8'h08);
    check("midrst_count", {6'b0, qcount}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    tick(4'b0);
    tick(4'b0);
    check("post_rst_dir", {4'b0, dir}, 8'h08);
    check("post_rst_count", {6'b0, qcount}, 8'h00);
    check("pending_events", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
